// File: rtl/bus_rr.sv
// Two-master round-robin system bus with windowed slave decode and
// programmable read latency; done/err handshake per transfer.
module bus_rr #(
  parameter int unsigned          AW      = 16,
  parameter int unsigned          DW      = 64,
  parameter int unsigned          NS      = 2,
  parameter logic [NS*AW-1:0]     S_BASE  = {16'h7000, 16'h0000},
  parameter logic [NS*AW-1:0]     S_LIMIT = {16'h71ff, 16'h07ff},
  parameter int unsigned          RD_LAT  = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             m0_req,
  input  logic             m1_req,
  input  logic             m0_wr,
  input  logic             m1_wr,
  input  logic [AW-1:0]    m0_addr,
  input  logic [AW-1:0]    m1_addr,
  input  logic [DW-1:0]    m0_dout,
  input  logic [DW-1:0]    m1_dout,
  output logic             m0_grant,
  output logic             m1_grant,
  output logic [DW-1:0]    m0_din,
  output logic [DW-1:0]    m1_din,
  output logic             m0_done,
  output logic             m1_done,
  output logic             m_err,
  output logic [NS-1:0]    s_sel,
  output logic [AW-1:0]    s_addr,
  output logic             s_wr,
  output logic [DW-1:0]    s_din,
  input  logic [NS*DW-1:0] s_dout
);

  localparam int unsigned CW = $clog2(RD_LAT + 2);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    XFER  = 2'd2
  } state_t;

  state_t          state, state_nx;
  logic            owner;
  logic            last;
  logic            miss;
  logic [CW-1:0]   cnt;
  logic            win;
  logic            tie;
  logic            own_wr;
  logic [AW-1:0]   own_addr;
  logic [DW-1:0]   own_dout;
  logic            xfer_last;
  logic            done;
  logic [NS-1:0]   dec_sel;
  logic            dec_hit;
  logic [DW-1:0]   rd_data;

  assign own_wr    = owner ? m1_wr   : m0_wr;
  assign own_addr  = owner ? m1_addr : m0_addr;
  assign own_dout  = owner ? m1_dout : m0_dout;
  assign tie       = m0_req & m1_req;
  assign win       = tie ? ~last : m1_req;
  assign xfer_last = own_wr || (cnt == CW'(RD_LAT));
  assign done      = (state == XFER) && xfer_last;

  always_comb begin
    state_nx = IDLE;
    case (state)
      IDLE:    state_nx = (m0_req || m1_req) ? GRANT : IDLE;
      GRANT:   state_nx = XFER;
      XFER:    state_nx = xfer_last ? IDLE : XFER;
      default: state_nx = IDLE;
    endcase
  end

  // Window test as (addr - base) <= (limit - base): same result as the
  // two-sided compare but never a constant compare against a zero base.
  always_comb begin
    dec_sel = '0;
    dec_hit = 1'b0;
    for (int unsigned i = 0; i < NS; i++) begin
      if (!dec_hit && (S_BASE[i*AW +: AW] <= S_LIMIT[i*AW +: AW]) &&
          ((own_addr - S_BASE[i*AW +: AW]) <=
           (S_LIMIT[i*AW +: AW] - S_BASE[i*AW +: AW]))) begin
        dec_sel[i] = 1'b1;
        dec_hit    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      owner <= 1'b0;
      last  <= 1'b1;
      s_sel <= '0;
      miss  <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && (m0_req || m1_req)) begin
        owner <= win;
        if (tie) last <= win;
      end
      if (state == GRANT) begin
        s_sel <= dec_sel;
        miss  <= ~dec_hit;
        cnt   <= '0;
      end else if (state == XFER) begin
        if (xfer_last) begin
          s_sel <= '0;
          miss  <= 1'b0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int unsigned i = 0; i < NS; i++) begin
      if (s_sel[i]) rd_data = s_dout[i*DW +: DW];
    end
  end

  assign m0_grant = ((state == GRANT) || (state == XFER)) && !owner;
  assign m1_grant = ((state == GRANT) || (state == XFER)) && owner;
  assign m0_done  = done && !owner;
  assign m1_done  = done && owner;
  assign m_err    = done && miss;
  assign m0_din   = (!owner && (s_sel != '0)) ? rd_data : '0;
  assign m1_din   = (owner && (s_sel != '0)) ? rd_data : '0;
  assign s_addr   = own_addr;
  assign s_din    = own_dout;
  assign s_wr     = own_wr && (state == XFER) && !miss;

endmodule
